// File: rtl/serial_subtractor16.sv
// Bit-serial unsigned subtractor: Diff = {0, Bout, A - B - Bin}, one bit per clock, LSB first.
// Result format matches the 16-bit ripple-carry adder's zero-extended Sum.
module serial_subtractor16 #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 Bin,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   Diff
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [WIDTH-1:0]  a_sr;
  logic [WIDTH-1:0]  b_sr;
  logic [WIDTH-1:0]  d_sr;
  logic [CW-1:0]     cnt;
  logic              borrow;

  logic a_bit;
  logic b_bit;
  logic d_bit;
  logic borrow_next;
  logic last_bit;

  // Single full-subtractor cell fed from the LSBs of the operand shift registers.
  always_comb begin
    a_bit       = a_sr[0];
    b_bit       = b_sr[0];
    d_bit       = a_bit ^ b_bit ^ borrow;
    borrow_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow);
    last_bit    = (cnt == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Diff is only written on the final RUN edge, so it never shows partial results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      d_sr   <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      Diff   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= A;
            b_sr   <= B;
            borrow <= Bin;
            cnt    <= '0;
            d_sr   <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          d_sr   <= {d_bit, d_sr[WIDTH-1:1]};
          borrow <= borrow_next;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            Diff <= {{(WIDTH-1){1'b0}}, borrow_next, d_bit, d_sr[WIDTH-1:1]};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor16.sv
// Directed and random checks of serial_subtractor16 against an arithmetic reference model.
`timescale 1ns/1ps
module tb_serial_subtractor16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        Bin;
  logic        busy;
  logic        done;
  logic [31:0] Diff;

  int checks = 0;
  int errors = 0;

  serial_subtractor16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [16:0] r;
    r = {1'b0, a} - {1'b0, b} - {16'b0, bin};
    return {15'b0, r};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sample index k is the negedge after edge E_k, where E0 accepts start.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input bit disturb, output logic [31:0] got, output int busy_cycles,
                        output int done_cycle, output int done_pulses, output int glitches);
    logic [31:0] prev;
    busy_cycles = 0;
    done_cycle  = -1;
    done_pulses = 0;
    glitches    = 0;
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    prev = Diff;
    got  = Diff;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      if (disturb && (k == 3 || k == 10)) begin
        start = 1'b1; A = ~a; B = a ^ 16'h5A5A; Bin = ~bin;
      end else if (disturb) begin
        start = 1'b0;
      end
      if (busy) busy_cycles++;
      if (done) begin
        done_pulses++;
        done_cycle = k;
        got = Diff;
      end else if (done_pulses == 0 && Diff !== prev) begin
        glitches++;
      end
    end
    start = 1'b0;
  endtask

  task automatic op_and_check(input string name, input logic [15:0] a, input logic [15:0] b,
                              input logic bin, input logic [31:0] exp, input bit disturb);
    logic [31:0] got;
    int bc, dc, dp, gl;
    run_op(a, b, bin, disturb, got, bc, dc, dp, gl);
    check({name, "_diff"}, got, exp);
    check({name, "_busy_cycles"}, 32'(bc), 32'd16);
    check({name, "_done_cycle"}, 32'(dc), 32'd16);
    check({name, "_done_pulses"}, 32'(dp), 32'd1);
    check({name, "_glitches"}, 32'(gl), 32'd0);
  endtask

  vec_t vecs [10];

  initial begin
    int seen, cyc, last_done, ndone;
    logic [31:0] exp_q [$];
    logic [31:0] e;

    vecs[0] = '{16'h0000, 16'h0000, 1'b0, 32'h0000_0000};
    vecs[1] = '{16'h0005, 16'h0003, 1'b0, 32'h0000_0002};
    vecs[2] = '{16'h000A, 16'h0005, 1'b0, 32'h0000_0005};
    vecs[3] = '{16'h0000, 16'h0001, 1'b0, 32'h0001_FFFF};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h0001_FFFF};
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 32'h0000_7FFF};
    vecs[6] = '{16'h1234, 16'h0234, 1'b1, 32'h0000_0FFF};
    vecs[7] = '{16'h0000, 16'h0000, 1'b1, 32'h0001_FFFF};
    vecs[8] = '{16'hFFFF, 16'h0000, 1'b0, 32'h0000_FFFF};
    vecs[9] = '{16'h0003, 16'h0005, 1'b0, 32'h0001_FFFE};

    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_diff", Diff, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      op_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp, 1'b0);
    end

    // Operand changes and start re-assertion during RUN must be ignored.
    op_and_check("disturb", 16'hBEEF, 16'h1234, 1'b1, 32'h0000_ACBA, 1'b1);

    // Asynchronous reset at RUN cycle 8 aborts the operation.
    @(negedge clk);
    A = 16'h0005; B = 16'h0003; Bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_diff", Diff, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    check("abort_diff_held", Diff, 32'd0);
    op_and_check("after_abort", 16'h000A, 16'h0005, 1'b0, 32'h0000_0005, 1'b0);

    // Random operands with start held high: one result every 18 cycles.
    seen = 0; cyc = 0; last_done = -1;
    @(negedge clk);
    A = 16'($urandom); B = 16'($urandom); Bin = 1'($urandom);
    exp_q.push_back(model(A, B, Bin));
    start = 1'b1;
    while (seen < 1000 && cyc < 1000 * 18 + 200) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check($sformatf("rand%0d_diff", seen), Diff, e);
        if (last_done >= 0) check($sformatf("rand%0d_spacing", seen), 32'(cyc - last_done), 32'd18);
        last_done = cyc;
        seen++;
        if (seen < 1000) begin
          A = 16'($urandom); B = 16'($urandom); Bin = 1'($urandom);
          exp_q.push_back(model(A, B, Bin));
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("rand_completed", 32'(seen), 32'd1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
